dac_wave_gen: RTL
=================

# dac_wave_gen

- Frame-synchronous 12-bit waveform source for the PMOD DAC serial controller; sits directly upstream of it and drives its 12-bit sample input.
- Phase-accumulator (DDS) generator with saw, square, triangle and quarter-wave-LUT sine outputs, plus power-of-two attenuation about midscale.
- Advances exactly one sample per 17-cycle DAC frame; the sample changes only in the frame's CS-high slot, so it is never modified while bits are shifting.

## Interface
- FRAME_LEN, 17: clock cycles per DAC frame; must equal the serializer period (count 0..16).
- PHASE_W, 16: phase accumulator width; minimum 16.
- clock  in  1  system clock, shared with the serializer (serializer SCLK = clock).
- resetn  in  1  reset, asynchronous, active-low; shared with the serializer.
- enable  in  1  1 = run; 0 = hold phase, output midscale.
- wave_sel  in  2  00 saw, 01 square, 10 triangle, 11 sine.
- freq_word  in  PHASE_W  phase increment per frame.
- amp_shift  in  2  attenuation: arithmetic right shift of (sample − 2048) by 0..3.
- sample  out  12  unsigned offset-binary DAC code, connects to serializer datain.
- frame_strobe  out  1  one-cycle pulse, first cycle of each new sample.

## Operation
- frame_cnt: 0..FRAME_LEN−1, free-running from reset; wraps FRAME_LEN−1 → 0. It mirrors the serializer count because both leave reset on the same edge.
- Update edge: the rising edge on which frame_cnt == FRAME_LEN−1.
  - Every register below changes only on an update edge, except frame_cnt and frame_strobe.
  - enable, wave_sel, freq_word and amp_shift are sampled only on update edges.
- At each update edge with enable=1:
  - sample ← f(phase).
  - phase ← phase + freq_word, modulo 2^PHASE_W.
  - f() uses the pre-increment phase.
- At each update edge with enable=0:
  - sample ← 2048.
  - phase holds.
- Raw waveform, with p = phase[PHASE_W−1 -: 16]:
  - Saw: p[15:4].
  - Square: p[15] ? 4095 : 0.
  - Triangle: p[15] ? ~p[14:3] : p[14:3]. Peak 4095 at p=0x7FF8.
  - Sine:
    - i = p[14] ? ~p[13:8] : p[13:8].
    - m = LUT[i], 11-bit, where LUT[k] = round(2047·sin(π/2·(k+0.5)/64)) for k = 0..63.
    - Output = p[15] ? 2047 − m : 2048 + m.
- Attenuation:
  - d = raw − 2048, 13-bit signed.
  - out = 2048 + (d >>> amp_shift).
  - The result is always within 0..4095; no saturation logic is needed.
- frame_strobe = 1 exactly when frame_cnt == 0, after the first update edge; otherwise 0.
- freq_word = 0 with enable=1: phase is frozen and the output is constant f(phase).

## Timing
- Reset values: frame_cnt=0, phase=0, sample=2048, frame_strobe=0.
- First update edge: the 17th rising edge after reset release.
  - sample stays 2048 for the first 17 cycles.
  - The first new code appears at frame_cnt=0 of the second frame.
- Stability: sample is constant from frame_cnt=0 through frame_cnt=16 of every frame. The serializer reads bits during counts 4..15, so no tearing can occur.
- Latency: a control change present at update edge N affects sample immediately after edge N. A change after edge N takes effect at update edge N+1, up to 17 cycles later.
- Sine path: combinational LUT read plus attenuation feeds the sample register; one register stage only.
- Reset mid-frame: all state returns to reset values asynchronously; the serializer resets on the same signal, so alignment is retained.
- Simultaneous enable fall and wave_sel change on an update edge: enable dominates, sample=2048.

## Structure
- Shared package dac_pkg:
  - FRAME_LEN.
  - MIDSCALE = 12'd2048.
  - Wave-select encodings: WAVE_SAW, WAVE_SQR, WAVE_TRI, WAVE_SIN.
- Sub-module sine_quarter_rom: 6-bit address in, 11-bit magnitude out, combinational case table generated from the LUT formula above.
- Top level holds frame_cnt, the phase accumulator, the waveform mux, attenuation and the output register.

## Test plan
- Reset, enable=1, wave_sel=00, freq_word=0x1000, amp_shift=0 → sample=2048 for cycles 0..16; then 0x000, 0x100, 0x200, … one step per 17 cycles; wraps 0xF00 → 0x000.
- Square, freq_word=0x2000 → 4 frames of 0 then 4 frames of 4095, repeating; frame_strobe pulses once every 17 cycles.
- Sine, freq_word=0x0100, amp_shift=0 → samples equal the golden model: first sample 2048+LUT[0]=2073; peak 4095 at phase 0x3F00 (i=63, m=2047); negative-half values equal 2047−m.
- Triangle, amp_shift=2 → peak 2048+((4095−2048)>>>2)=2559; trough 2048+((0−2048)>>>2)=1536.
- enable deasserted mid-frame → sample unchanged until the next update edge, then 2048. Phase frozen: re-enabling resumes from the held phase.
- Assert resetn mid-frame at frame_cnt=9 → immediate sample=2048, frame_cnt=0. A checker confirms sample never changes while serializer count is in 4..15, for all runs.

Source files
------------

// File: rtl/dac_wave_gen_pkg.sv
// Shared constants and helpers for the frame-synchronous DAC waveform source.
// Wave-select encodings and midscale-centred attenuation.
package dac_pkg;

  localparam int FRAME_LEN = 17;
  localparam logic [11:0] MIDSCALE = 12'd2048;

  typedef enum logic [1:0] {
    WAVE_SAW = 2'b00,
    WAVE_SQR = 2'b01,
    WAVE_TRI = 2'b10,
    WAVE_SIN = 2'b11
  } wave_e;

  // Shift the signed offset from midscale, then re-bias; cannot overflow.
  function automatic logic [11:0] atten(
    input logic [11:0] raw,
    input logic [1:0]  sh
  );
    logic signed [12:0] d;
    d = $signed({1'b0, raw}) - 13'sd2048;
    d = d >>> sh;
    d = d + 13'sd2048;
    return d[11:0];
  endfunction

endpackage

// File: rtl/dac_wave_gen_if.sv
// Control and sample bundle between the waveform source and its user.
// The serializer-side consumer reads sample and frame_strobe.
interface dac_wave_gen_if #(
  parameter int PHASE_W = 16
);
  logic               enable;
  logic [1:0]         wave_sel;
  logic [PHASE_W-1:0] freq_word;
  logic [1:0]         amp_shift;
  logic [11:0]        sample;
  logic               frame_strobe;

  modport master (
    output enable, wave_sel, freq_word, amp_shift,
    input  sample, frame_strobe
  );

  modport slave (
    input  enable, wave_sel, freq_word, amp_shift,
    output sample, frame_strobe
  );
endinterface

// File: rtl/dac_wave_gen_rom.sv
// Quarter-wave sine magnitude table, 64 x 11 bit, combinational.
// Entry k = round(2047 * sin(pi/2 * (k + 0.5) / 64)).
module sine_quarter_rom (
  input  logic [5:0]  addr,
  output logic [10:0] mag
);
  always_comb begin
    mag = '0;
    case (addr)
      6'd0:  mag = 11'd25;   6'd1:  mag = 11'd75;
      6'd2:  mag = 11'd126;  6'd3:  mag = 11'd176;
      6'd4:  mag = 11'd226;  6'd5:  mag = 11'd275;
      6'd6:  mag = 11'd325;  6'd7:  mag = 11'd375;
      6'd8:  mag = 11'd424;  6'd9:  mag = 11'd473;
      6'd10: mag = 11'd522;  6'd11: mag = 11'd570;
      6'd12: mag = 11'd618;  6'd13: mag = 11'd666;
      6'd14: mag = 11'd713;  6'd15: mag = 11'd760;
      6'd16: mag = 11'd807;  6'd17: mag = 11'd852;
      6'd18: mag = 11'd898;  6'd19: mag = 11'd943;
      6'd20: mag = 11'd987;  6'd21: mag = 11'd1031;
      6'd22: mag = 11'd1074; 6'd23: mag = 11'd1116;
      6'd24: mag = 11'd1158; 6'd25: mag = 11'd1199;
      6'd26: mag = 11'd1239; 6'd27: mag = 11'd1279;
      6'd28: mag = 11'd1318; 6'd29: mag = 11'd1356;
      6'd30: mag = 11'd1393; 6'd31: mag = 11'd1430;
      6'd32: mag = 11'd1465; 6'd33: mag = 11'd1500;
      6'd34: mag = 11'd1533; 6'd35: mag = 11'd1566;
      6'd36: mag = 11'd1598; 6'd37: mag = 11'd1629;
      6'd38: mag = 11'd1659; 6'd39: mag = 11'd1688;
      6'd40: mag = 11'd1716; 6'd41: mag = 11'd1743;
      6'd42: mag = 11'd1769; 6'd43: mag = 11'd1793;
      6'd44: mag = 11'd1817; 6'd45: mag = 11'd1840;
      6'd46: mag = 11'd1861; 6'd47: mag = 11'd1881;
      6'd48: mag = 11'd1901; 6'd49: mag = 11'd1919;
      6'd50: mag = 11'd1936; 6'd51: mag = 11'd1951;
      6'd52: mag = 11'd1966; 6'd53: mag = 11'd1979;
      6'd54: mag = 11'd1992; 6'd55: mag = 11'd2003;
      6'd56: mag = 11'd2012; 6'd57: mag = 11'd2021;
      6'd58: mag = 11'd2028; 6'd59: mag = 11'd2035;
      6'd60: mag = 11'd2039; 6'd61: mag = 11'd2043;
      6'd62: mag = 11'd2046; 6'd63: mag = 11'd2047;
      default: mag = '0;
    endcase
  end
endmodule

// File: rtl/dac_wave_gen.sv
// DDS waveform source for the PMOD DAC serializer.
// One new sample per frame, loaded only in the CS-high slot.
module dac_wave_gen
  import dac_pkg::*;
#(
  parameter int PHASE_W = 16
) (
  input logic        clock,
  input logic        resetn,
  dac_wave_gen_if.slave bus
);

  localparam int CW = $clog2(FRAME_LEN);

  logic [CW-1:0]      frame_cnt;
  logic [PHASE_W-1:0] phase;
  logic [11:0]        sample_q;
  logic               strobe_q;
  logic [15:0]        p;
  logic               upd;
  logic [5:0]         rom_addr;
  logic [10:0]        mag;
  logic [11:0]        raw;
  logic [11:0]        nxt;
  logic               unused_bits;

  assign p           = phase[PHASE_W-1 -: 16];
  assign upd         = (frame_cnt == CW'(FRAME_LEN - 1));
  assign rom_addr    = p[14] ? ~p[13:8] : p[13:8];
  assign unused_bits = ^p[2:0];

  sine_quarter_rom u_rom (
    .addr (rom_addr),
    .mag  (mag)
  );

  always_comb begin
    raw = MIDSCALE;
    unique case (wave_e'(bus.wave_sel))
      WAVE_SAW: raw = p[15:4];
      WAVE_SQR: raw = {12{p[15]}};
      WAVE_TRI: raw = p[15] ? ~p[14:3] : p[14:3];
      WAVE_SIN: raw = p[15] ? 12'd2047 - {1'b0, mag}
                            : MIDSCALE + {1'b0, mag};
    endcase
  end

  // Disable wins over any simultaneous waveform change.
  assign nxt = bus.enable ? atten(raw, bus.amp_shift) : MIDSCALE;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frame_cnt <= '0;
      phase     <= '0;
      sample_q  <= MIDSCALE;
      strobe_q  <= 1'b0;
    end else begin
      frame_cnt <= upd ? '0 : frame_cnt + 1'b1;
      strobe_q  <= upd;
      if (upd) begin
        sample_q <= nxt;
        if (bus.enable)
          phase <= phase + bus.freq_word;
      end
    end
  end

  assign bus.sample       = sample_q;
  assign bus.frame_strobe = strobe_q;

endmodule
